// File: rtl/gb_serial_pkg.sv
// gb_serial_pkg: shared types and constants for the Game Boy link-port controller
package gb_serial_pkg;
  typedef enum logic [1:0] {IDLE, INT_LOW, INT_HIGH, EXT_WAIT} state_t;
  localparam logic REG_SB = 1'b0;
  localparam logic REG_SC = 1'b1;
  localparam logic [5:0] SC_UNUSED = 6'b111111;
  localparam logic [3:0] BITS_PER_XFER = 4'd8;
endpackage

// File: rtl/gb_serial_link_sync_edge_detect.sv
// sync_edge_detect: metastability chain for an async pin plus edge detection on the synchronized value
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic prev;
  // shift the pin through the chain and remember last cycle's synchronized level
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= STAGES'({chain, d});
      prev  <= chain[STAGES-1];
    end
  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;
endmodule

// File: rtl/gb_serial_link.sv
// gb_serial_link: SB/SC registers and link-cable shift engine, master on internal clock or slave on external clock
module gb_serial_link
  import gb_serial_pkg::*;
#(
  parameter int CLK_DIV     = 512,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reg_sel,
  input  logic       wr_en,
  output logic [7:0] rd_data,
  input  logic [7:0] wr_data,
  input  logic       sclk_in,
  output logic       sclk_out,
  output logic       sclk_oe,
  input  logic       sin,
  output logic       sout,
  output logic       irq_serial
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  state_t state;
  logic [7:0] sb;
  logic start, clk_sel;
  logic [3:0] bit_cnt;
  logic [DW-1:0] div_cnt, div_next;
  logic [SYNC_STAGES-1:0] sin_chain;
  logic sin_s, sclk_s, sclk_rise, sclk_fall;
  logic done, idle_wr;
  logic [7:0] sb_shift;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clock (clock),
    .reset (reset),
    .d     (sclk_in),
    .sync  (sclk_s),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // data pin only needs a plain synchronizer, its edges carry no meaning
  always_ff @(posedge clock or negedge reset)
    if (!reset) sin_chain <= '1;
    else sin_chain <= SYNC_STAGES'({sin_chain, sin});
  assign sin_s = sin_chain[SYNC_STAGES-1];

  assign rd_data  = (reg_sel == REG_SC) ? {start, SC_UNUSED, clk_sel} : sb;
  assign sclk_oe  = clk_sel;
  assign sb_shift = {sb[6:0], sin_s};
  assign div_next = (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
  assign done     = bit_cnt == BITS_PER_XFER &&
                    ((state == INT_LOW && div_cnt == '0) || state == EXT_WAIT);
  assign idle_wr  = state == IDLE || done;

  // transfer engine and register writes; completion beats a same-cycle SC write, which then acts as an idle write
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      sb         <= 8'h00;
      start      <= 1'b0;
      clk_sel    <= 1'b0;
      bit_cnt    <= 4'd0;
      div_cnt    <= '0;
      sclk_out   <= 1'b1;
      sout       <= 1'b1;
      irq_serial <= 1'b0;
    end else begin
      irq_serial <= 1'b0;
      case (state)
        INT_LOW: begin
          div_cnt <= div_next;
          if (div_cnt == '0 && !done) begin
            sclk_out <= 1'b0;
            sout     <= sb[7];
          end
          if (div_cnt == HALF) begin
            sclk_out <= 1'b1;
            sb       <= sb_shift;
            bit_cnt  <= bit_cnt + 1'b1;
            state    <= INT_HIGH;
          end
        end
        INT_HIGH: begin
          div_cnt <= div_next;
          if (div_cnt == LAST) state <= INT_LOW;
        end
        EXT_WAIT:
          if (!done && (sclk_rise || sclk_fall)) begin
            if (sclk_s) begin
              sb      <= sb_shift;
              bit_cnt <= bit_cnt + 1'b1;
            end else sout <= sb[7];
          end
        default: ;
      endcase
      if (done) begin
        start      <= 1'b0;
        irq_serial <= 1'b1;
        state      <= IDLE;
        div_cnt    <= '0;
      end
      if (wr_en && reg_sel == REG_SB && state == IDLE) sb <= wr_data;
      if (wr_en && reg_sel == REG_SC) begin
        if (idle_wr) begin
          clk_sel <= wr_data[0];
          if (wr_data[7]) begin
            start   <= 1'b1;
            bit_cnt <= 4'd0;
            div_cnt <= '0;
            sout    <= sb[7];
            state   <= wr_data[0] ? INT_LOW : EXT_WAIT;
          end
        end else if (!wr_data[7]) begin
          state    <= IDLE;
          start    <= 1'b0;
          sclk_out <= 1'b1;
          div_cnt  <= '0;
        end
      end
    end
endmodule

// File: tb/tb_gb_serial_link.sv
// tb_gb_serial_link: scoreboard bench for the link-port controller with CLK_DIV=8
module tb_gb_serial_link;
  localparam int CD = 8;
  logic clock = 1'b0, reset = 1'b0, reg_sel = 1'b0, wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic sclk_in = 1'b1, sin_drv = 1'b1, loop = 1'b0;
  logic sin;
  logic [7:0] rd_data;
  logic sclk_out, sclk_oe, sout, irq_serial;
  int compared = 0, mismatched = 0, irq_cnt = 0, irq0;
  bit mon_en = 1'b0;
  logic prev_sclk = 1'b1;
  logic exp_bits[$];
  logic [7:0] exp_sb[$];
  logic [7:0] v;

  assign sin = loop ? sout : sin_drv;

  gb_serial_link #(.CLK_DIV(CD), .SYNC_STAGES(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .reg_sel    (reg_sel),
    .wr_en      (wr_en),
    .rd_data    (rd_data),
    .wr_data    (wr_data),
    .sclk_in    (sclk_in),
    .sclk_out   (sclk_out),
    .sclk_oe    (sclk_oe),
    .sin        (sin),
    .sout       (sout),
    .irq_serial (irq_serial)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [7:0] d);
    @(negedge clock);
    reg_sel = sel;
    wr_data = d;
    wr_en = 1'b1;
    @(negedge clock);
    wr_en = 1'b0;
    reg_sel = 1'b0;
  endtask

  task automatic rd(input logic sel, output logic [7:0] q);
    reg_sel = sel;
    #1;
    q = rd_data;
    reg_sel = 1'b0;
  endtask

  // scoreboard side: pop expected sout on each internal falling edge, expected SB on each irq
  always @(negedge clock) begin
    if (irq_serial) begin
      irq_cnt++;
      if (exp_sb.size() > 0) chk("sb_at_irq", rd_data, exp_sb.pop_front());
    end
    if (mon_en && prev_sclk && !sclk_out && exp_bits.size() > 0)
      chk("sout_bit", sout, exp_bits.pop_front());
    prev_sclk = sclk_out;
  end

  task automatic run_int(input logic [7:0] sb0, input logic [7:0] remote, input bit lb);
    logic ec;
    loop = lb;
    sin_drv = 1'b1;
    wr(1'b0, sb0);
    for (int k = 0; k < 8; k++) exp_bits.push_back(sb0[7-k]);
    exp_sb.push_back(lb ? sb0 : remote);
    mon_en = 1'b1;
    wr(1'b1, 8'h81);
    chk("int_oe", sclk_oe, 1);
    for (int n = 1; n <= 70; n++) begin
      @(negedge clock);
      ec = (n <= 8 * CD) ? ((n - 1) % CD >= CD / 2) : 1'b1;
      chk("int_sclk", sclk_out, ec);
      chk("int_irq", irq_serial, n == 8 * CD + 1);
      if (!lb && n % CD == 1 && n <= 7 * CD + 1) sin_drv = remote[7-(n-1)/CD];
    end
    mon_en = 1'b0;
    loop = 1'b0;
    chk("bits_left", exp_bits.size(), 0);
    chk("sb_left", exp_sb.size(), 0);
    rd(1'b0, v);
    chk("int_sb_final", v, lb ? sb0 : remote);
    rd(1'b1, v);
    chk("int_sc_final", v, 8'h7F);
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] sbx;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    rd(1'b0, v); chk("rst_sb", v, 8'h00);
    rd(1'b1, v); chk("rst_sc", v, 8'h7E);
    chk("rst_sclk", sclk_out, 1);
    chk("rst_oe", sclk_oe, 0);
    chk("rst_sout", sout, 1);
    chk("rst_irq", irq_serial, 0);

    run_int(8'hA5, 8'h00, 1'b1);
    run_int(8'h3C, 8'hC3, 1'b0);

    pat = 8'hF0;
    sbx = 8'h5A;
    wr(1'b0, sbx);
    exp_sb.push_back(pat);
    wr(1'b1, 8'h80);
    chk("ext_oe", sclk_oe, 0);
    irq0 = irq_cnt;
    for (int k = 0; k < 8; k++) begin
      sclk_in = 1'b0;
      sin_drv = pat[7-k];
      exp_bits.push_back(sbx[7-k]);
      repeat (10) @(negedge clock);
      chk("ext_sout", sout, exp_bits.pop_front());
      sclk_in = 1'b1;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clock);
        if (k == 7) chk("ext_irq", irq_serial, i == 4);
      end
    end
    chk("ext_irq_cnt", irq_cnt - irq0, 1);
    chk("ext_sb_left", exp_sb.size(), 0);
    sin_drv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sclk_in = 1'b0;
      repeat (10) @(negedge clock);
      sclk_in = 1'b1;
      repeat (10) @(negedge clock);
    end
    rd(1'b0, v); chk("ext_idle_sb", v, 8'hF0);
    rd(1'b1, v); chk("ext_idle_sc", v, 8'h7E);
    chk("ext_idle_irq", irq_cnt - irq0, 1);

    wr(1'b0, 8'h96);
    wr(1'b1, 8'h81);
    repeat (26) @(negedge clock);
    chk("abort_pre_sclk", sclk_out, 0);
    irq0 = irq_cnt;
    wr(1'b1, 8'h01);
    chk("abort_sclk", sclk_out, 1);
    rd(1'b1, v); chk("abort_sc", v, 8'h7F);
    rd(1'b0, v); chk("abort_sb", v, 8'hB7);
    repeat (80) @(negedge clock);
    chk("abort_irq", irq_cnt - irq0, 0);
    chk("abort_sclk_hold", sclk_out, 1);
    wr(1'b0, 8'h11);
    rd(1'b0, v); chk("abort_sb_wr", v, 8'h11);

    wr(1'b0, 8'h00);
    wr(1'b1, 8'h81);
    repeat (29) @(negedge clock);
    chk("mid_oe", sclk_oe, 1);
    chk("mid_sout", sout, 0);
    irq0 = irq_cnt;
    #2 reset = 1'b0;
    #1;
    chk("arst_sclk", sclk_out, 1);
    chk("arst_oe", sclk_oe, 0);
    chk("arst_sout", sout, 1);
    chk("arst_irq", irq_serial, 0);
    rd(1'b0, v); chk("arst_sb", v, 8'h00);
    rd(1'b1, v); chk("arst_sc", v, 8'h7E);
    reset = 1'b1;
    repeat (80) @(negedge clock);
    chk("arst_no_irq", irq_cnt - irq0, 0);
    chk("arst_sclk_hold", sclk_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
